// File: rtl/rv_iopmp_axi4_err_slv_pkg.sv
// Shared AXI response/length types and the error-responder FSM state encodings.
package axi_pkg;
    typedef logic [7:0] len_t;
    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
endpackage

package rv_iopmp_pkg;
    typedef enum logic {
        R_IDLE,
        R_BEATS
    } err_rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DRAIN,
        W_RESP
    } err_wr_state_e;
endpackage

// File: rtl/rv_iopmp_axi4_err_slv_if.sv
// Bundle of the rejected-request, R, W and B channels seen by the error responder.
interface rv_iopmp_axi4_err_slv_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64
);
    logic                  rd_err_valid_i;
    logic                  rd_err_ready_o;
    logic [ID_WIDTH-1:0]   rd_err_id_i;
    logic [7:0]            rd_err_len_i;
    logic                  r_valid_o;
    logic                  r_ready_i;
    logic [ID_WIDTH-1:0]   r_id_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic [1:0]            r_resp_o;
    logic                  r_last_o;
    logic                  wr_err_valid_i;
    logic                  wr_err_ready_o;
    logic [ID_WIDTH-1:0]   wr_err_id_i;
    logic [7:0]            wr_err_len_i;
    logic                  w_valid_i;
    logic                  w_last_i;
    logic                  w_ready_o;
    logic                  b_valid_o;
    logic                  b_ready_i;
    logic [ID_WIDTH-1:0]   b_id_o;
    logic [1:0]            b_resp_o;

    // Upstream side: checker/IOPMP presenting rejects, master consuming R/B and sending W.
    modport master (
        output rd_err_valid_i, rd_err_id_i, rd_err_len_i, r_ready_i,
        output wr_err_valid_i, wr_err_id_i, wr_err_len_i, w_valid_i, w_last_i, b_ready_i,
        input  rd_err_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        input  wr_err_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o
    );

    // Error responder side.
    modport slave (
        input  rd_err_valid_i, rd_err_id_i, rd_err_len_i, r_ready_i,
        input  wr_err_valid_i, wr_err_id_i, wr_err_len_i, w_valid_i, w_last_i, b_ready_i,
        output rd_err_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
        output wr_err_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o
    );
endinterface

// File: rtl/rv_iopmp_axi4_err_wr.sv
// Write-side error responder: accepts a rejected AW, discards its W burst, returns one B error.
module rv_iopmp_axi4_err_wr
    import axi_pkg::*;
    import rv_iopmp_pkg::*;
#(
    parameter int    ID_WIDTH = 4,
    parameter resp_t ERR_RESP = RESP_SLVERR
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_err_valid_i,
    output logic                wr_err_ready_o,
    input  logic [ID_WIDTH-1:0] wr_err_id_i,
    input  len_t                wr_err_len_i,
    input  logic                w_valid_i,
    input  logic                w_last_i,
    output logic                w_ready_o,
    output logic                b_valid_o,
    input  logic                b_ready_i,
    output logic [ID_WIDTH-1:0] b_id_o,
    output resp_t               b_resp_o,
    output logic                wlast_mismatch_o
);
    err_wr_state_e       state_q;
    logic [ID_WIDTH-1:0] id_q;
    len_t                len_q;
    logic [8:0]          cnt_q;
    logic [8:0]          cnt_d;
    logic [8:0]          len_ext;
    logic                aw_ready_q;
    logic                w_ready_q;
    logic                b_valid_q;

    assign cnt_d   = cnt_q + 9'd1;
    assign len_ext = {1'b0, len_q};

    // Write FSM: AW accept -> drain W until WLAST -> hold B until accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= W_IDLE;
            id_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (wr_err_valid_i) begin
                        id_q       <= wr_err_id_i;
                        len_q      <= wr_err_len_i;
                        cnt_q      <= '0;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        state_q    <= W_DRAIN;
                    end
                end
                W_DRAIN: begin
                    if (w_valid_i) begin
                        cnt_q <= cnt_d;
                        if (w_last_i) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            state_q   <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        state_q    <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

    // Flag a beat whose WLAST disagrees with its position relative to the latched AWLEN.
    assign wlast_mismatch_o = w_ready_q & w_valid_i &
                              (w_last_i ? (cnt_q != len_ext) : (cnt_q == len_ext));

    assign wr_err_ready_o = aw_ready_q;
    assign w_ready_o      = w_ready_q;
    assign b_valid_o      = b_valid_q;
    assign b_id_o         = id_q;
    assign b_resp_o       = b_valid_q ? ERR_RESP : RESP_OKAY;
endmodule

// File: rtl/rv_iopmp_axi4_err_slv.sv
// AXI4 error responder: terminates rejected AR/AW requests with error R beats / B response.
module rv_iopmp_axi4_err_slv
    import axi_pkg::*;
    import rv_iopmp_pkg::*;
#(
    parameter int    ID_WIDTH   = 4,
    parameter int    DATA_WIDTH = 64,
    parameter resp_t ERR_RESP   = RESP_SLVERR
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    rv_iopmp_axi4_err_slv_if.slave      bus,
    output logic                        wlast_mismatch_o
);
    err_rd_state_e       rd_state_q;
    len_t                rd_cnt_q;
    logic [ID_WIDTH-1:0] rd_id_q;
    logic                rd_ready_q;
    logic                r_valid_q;
    logic                r_last_q;

    // Read FSM: one AR accept, then len+1 error beats; RLAST is precomputed for the next beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_id_q    <= '0;
            rd_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (bus.rd_err_valid_i) begin
                        rd_id_q    <= bus.rd_err_id_i;
                        rd_cnt_q   <= bus.rd_err_len_i;
                        rd_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_last_q   <= (bus.rd_err_len_i == 8'd0);
                        rd_state_q <= R_BEATS;
                    end
                end
                R_BEATS: begin
                    if (bus.r_ready_i) begin
                        if (rd_cnt_q == 8'd0) begin
                            rd_ready_q <= 1'b1;
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_cnt_q <= rd_cnt_q - 8'd1;
                            r_last_q <= (rd_cnt_q == 8'd1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rd_err_ready_o = rd_ready_q;
    assign bus.r_valid_o      = r_valid_q;
    assign bus.r_id_o         = rd_id_q;
    assign bus.r_data_o       = '0;
    assign bus.r_resp_o       = r_valid_q ? ERR_RESP : RESP_OKAY;
    assign bus.r_last_o       = r_last_q;

    rv_iopmp_axi4_err_wr #(
        .ID_WIDTH (ID_WIDTH),
        .ERR_RESP (ERR_RESP)
    ) u_wr (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .wr_err_valid_i   (bus.wr_err_valid_i),
        .wr_err_ready_o   (bus.wr_err_ready_o),
        .wr_err_id_i      (bus.wr_err_id_i),
        .wr_err_len_i     (bus.wr_err_len_i),
        .w_valid_i        (bus.w_valid_i),
        .w_last_i         (bus.w_last_i),
        .w_ready_o        (bus.w_ready_o),
        .b_valid_o        (bus.b_valid_o),
        .b_ready_i        (bus.b_ready_i),
        .b_id_o           (bus.b_id_o),
        .b_resp_o         (bus.b_resp_o),
        .wlast_mismatch_o (wlast_mismatch_o)
    );
endmodule

// File: doc/rv_iopmp_axi4_err_slv.md
Name: rv_iopmp_axi4_err_slv

Overview:
Error responder that sits directly downstream of the AXI4 boundary checker and of the IOPMP permission check. It terminates any AR/AW that is flagged as a violation (4-KiB crossing or denied access) without forwarding it to the slave. For reads it returns len+1 R beats carrying an error response. For writes it drains the W burst and then returns a single B error response.

Parameters:
ID_WIDTH, 4, width of AXI ID fields.
DATA_WIDTH, 64, width of r_data_o.
ERR_RESP, axi_pkg::RESP_SLVERR, response code driven on RRESP/BRESP.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
rd_err_valid_i  in  1  rejected AR present
rd_err_ready_o  out  1  rejected AR accepted
rd_err_id_i  in  ID_WIDTH  ARID of rejected request
rd_err_len_i  in  8  ARLEN of rejected request
r_valid_o  out  1  R beat valid
r_ready_i  in  1  R beat accepted by master
r_id_o  out  ID_WIDTH  RID
r_data_o  out  DATA_WIDTH  RDATA; always 0
r_resp_o  out  2  RRESP
r_last_o  out  1  RLAST
wr_err_valid_i  in  1  rejected AW present
wr_err_ready_o  out  1  rejected AW accepted
wr_err_id_i  in  ID_WIDTH  AWID of rejected request
wr_err_len_i  in  8  AWLEN of rejected request
w_valid_i  in  1  W beat from master
w_last_i  in  1  WLAST
w_ready_o  out  1  W beat consumed (data discarded)
b_valid_o  out  1  B response valid
b_ready_i  in  1  B accepted by master
b_id_o  out  ID_WIDTH  BID
b_resp_o  out  2  BRESP
wlast_mismatch_o  out  1  one-cycle pulse: WLAST position disagrees with AWLEN

Behaviour:
- Reset (async, rst_ni=0): both FSMs go to IDLE; all counters and latched IDs are cleared.
  - Reset output values: rd_err_ready_o=1, wr_err_ready_o=1; all other outputs 0.
  - Reset mid-burst abandons the burst; no further beats or B are produced.
- Read FSM, states R_IDLE and R_BEATS:
  - R_IDLE: rd_err_ready_o=1. On rd_err_valid_i, latch the ID and load beat counter = rd_err_len_i; go to R_BEATS.
  - R_BEATS: rd_err_ready_o=0, r_valid_o=1, r_id_o=latched ID, r_data_o=0, r_resp_o=ERR_RESP, r_last_o=(counter==0).
  - On r_valid_o & r_ready_i: if counter==0 go to R_IDLE, else decrement the counter.
  - Without r_ready_i, all R outputs hold stable.
  - Latency: first beat appears 1 cycle after the AR handshake. Exactly len+1 beats are produced; len=255 gives 256 beats.
  - Back-to-back ARs incur one idle cycle (ready only in R_IDLE).
- Write FSM, states W_IDLE, W_DRAIN and W_RESP:
  - W_IDLE: wr_err_ready_o=1, w_ready_o=0 (W beats are not taken before AW is accepted). On wr_err_valid_i, latch the ID and wr_err_len_i, clear the beat counter, go to W_DRAIN.
  - W_DRAIN: w_ready_o=1. Each w_valid_i increments the 9-bit beat counter.
    - On w_valid_i & w_last_i, go to W_RESP.
    - wlast_mismatch_o pulses that cycle if counter != latched len.
    - It also pulses if a non-last beat arrives with counter == latched len. Drain continues until WLAST regardless.
  - W_RESP: w_ready_o=0, b_valid_o=1, b_id_o=latched ID, b_resp_o=ERR_RESP. On b_ready_i go to W_IDLE. Outputs are stable while waiting.
- Read and write FSMs are independent. Simultaneous rd/wr acceptance in the same cycle is legal.
- Counter widths: 8-bit read counter; 9-bit write counter so 256-beat bursts do not wrap.

Decomposition:
- rv_iopmp_pkg:
  - err_rd_state_e {R_IDLE, R_BEATS}
  - err_wr_state_e {W_IDLE, W_DRAIN, W_RESP}
- axi_pkg supplies len_t, resp_t and RESP_SLVERR/RESP_DECERR.
- One natural sub-module: rv_iopmp_axi4_err_wr (write drain + B FSM). The read path stays inline in the top.

Test Plan:
- AR id=3 len=3; r_ready_i held 1 -> 4 R beats on consecutive cycles starting 1 cycle after the handshake, RID=3, RRESP=2'b10, RDATA=0, RLAST only on beat 4; rd_err_ready_o back to 1 after the last beat.
- AR len=0 with r_ready_i low for 5 cycles -> single beat with r_last_o=1, held stable for 5 cycles, completes on the cycle r_ready_i rises.
- AW id=5 len=7, 8 W beats with WLAST on the 8th and gaps in w_valid_i -> all beats consumed, then b_valid_o with BID=5 and BRESP=2'b10; no mismatch pulse.
- AW len=3, WLAST on the 2nd beat -> wlast_mismatch_o pulses once; B is issued after that beat.
- AR len=255 and AW len=0 accepted in the same cycle -> 256 R beats and 1 B complete independently with correct IDs.
- Assert rst_ni low during beat 2 of a len=7 read -> r_valid_o=0 immediately; rd_err_ready_o=1 after release; no residual beats.
